// File: rtl/final_cond_sub.sv
// Purpose: fully reduce a lazily reduced Montgomery product a in [0,2m) to a mod m, one limb per cycle.
// Latency: en -> en_out is Size/Limb+1 cycles for final reduction, 2 cycles for pass-through
//          (Size/Limb+1 for both when FSUB_CONST_TIME_EN is defined).
// Backpressure: ready=0 while busy and during the en_out cycle; en is ignored then, with no queueing.
module final_cond_sub #(
    parameter int Size  = 3072,
    parameter int Limb  = 128,
    parameter int Cnt_w = 5
) (
    input  logic            clk,
    input  logic            rst_n,     // synchronous, active-high
    input  logic            en,
    input  logic            if_last,
    input  logic [Size:0]   a,
    input  logic [Size-1:0] m,
    output logic [Size-1:0] r,
    output logic            en_out,
    output logic            ready,
    output logic            sub_done
);

    localparam int NLimb = Size / Limb;

    typedef enum logic [1:0] {IDLE, SUB, PASS, DONE} state_t;

    state_t                state_q, state_d;
    logic [Cnt_w-1:0]      i_q, i_d;
    logic                  borrow_q, borrow_d;
    logic                  last_q, last_d;
    logic [Size:0]         a_q, a_d;
    logic [Size-1:0]       m_q, m_d;
    logic [Size-1:0]       d_q, d_d;
    logic [Size-1:0]       r_q, r_d;
    logic                  en_out_q, en_out_d;
    logic                  sub_done_q, sub_done_d;

    logic [Limb:0]         diff;
    logic                  take;
    int                    limb_base;
`ifdef FSUB_CONST_TIME_EN
    logic [Size-1:0]       take_mask;
`endif

    // Idle only once the result strobe has passed, so ready trails en_out by one cycle.
    assign ready    = (state_q == IDLE) && !en_out_q;
    assign r        = r_q;
    assign en_out   = en_out_q;
    assign sub_done = sub_done_q;

    // Next-state, limb-serial subtract and final select.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        borrow_d   = borrow_q;
        last_d     = last_q;
        a_d        = a_q;
        m_d        = m_q;
        d_d        = d_q;
        r_d        = r_q;
        en_out_d   = 1'b0;
        sub_done_d = sub_done_q;

        limb_base = int'(i_q) * Limb;
        diff      = {1'b0, a_q[limb_base +: Limb]} - {1'b0, m_q[limb_base +: Limb]}
                  - {{Limb{1'b0}}, borrow_q};
        // a >= m when the 2^Size bit is set or the full-width subtract did not borrow.
        take      = last_q & (a_q[Size] | ~borrow_q);
`ifdef FSUB_CONST_TIME_EN
        take_mask = {Size{take}};
`endif

        case (state_q)
            IDLE: begin
                if (en && ready) begin
                    a_d      = a;
                    m_d      = m;
                    borrow_d = 1'b0;
                    i_d      = '0;
                    last_d   = if_last;
`ifdef FSUB_CONST_TIME_EN
                    // Same limb sequence for both modes; only take differs.
                    state_d  = SUB;
`else
                    if (if_last) begin
                        state_d = SUB;
                    end else begin
                        d_d     = a[Size-1:0];
                        state_d = PASS;
                    end
`endif
                end
            end
            SUB: begin
                d_d[limb_base +: Limb] = diff[Limb-1:0];
                borrow_d = diff[Limb];
                i_d      = i_q + Cnt_w'(1);
                if (i_q == Cnt_w'(NLimb - 1)) begin
                    state_d = DONE;
                end
            end
            PASS: begin
                // One alignment cycle so pass-through emits two cycles after en.
                state_d = DONE;
            end
            DONE: begin
                en_out_d   = 1'b1;
                sub_done_d = take;
`ifdef FSUB_CONST_TIME_EN
                r_d = (d_q & take_mask) | (a_q[Size-1:0] & ~take_mask);
`else
                // Pass-through (last_q=0) carries its value in d_q.
                r_d = (take || !last_q) ? d_q : a_q[Size-1:0];
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            i_q        <= '0;
            borrow_q   <= 1'b0;
            r_q        <= '0;
            en_out_q   <= 1'b0;
            sub_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            borrow_q   <= borrow_d;
            r_q        <= r_d;
            en_out_q   <= en_out_d;
            sub_done_q <= sub_done_d;
        end
    end

    // Operand and difference registers; contents are don't-care outside an operation.
    always_ff @(posedge clk) begin
        last_q <= last_d;
        a_q    <= a_d;
        m_q    <= m_d;
        d_q    <= d_d;
    end

endmodule

// File: tb/tb_final_cond_sub.sv
module tb_final_cond_sub;

    localparam int S = 3072;

`ifdef FSUB_CONST_TIME_EN
    localparam int PassLat = 25;
`else
    localparam int PassLat = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         if_last;
    logic [S:0]   a;
    logic [S-1:0] m;
    logic [S-1:0] r;
    logic         en_out;
    logic         ready;
    logic         sub_done;

    int tests = 0;
    int fails = 0;
    int lat;
    int cnt;

    logic [S-1:0] m0;
    logic [S:0]   av;
    logic [S:0]   ones;

    final_cond_sub dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .if_last  (if_last),
        .a        (a),
        .m        (m),
        .r        (r),
        .en_out   (en_out),
        .ready    (ready),
        .sub_done (sub_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [S:0] obs, input logic [S:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed(low96)=%h required(low96)=%h", tag, obs[95:0], exp[95:0]);
        end
    endtask

    // Issue one op (inputs changed #1 after an edge), count edges until en_out.
    task automatic run_op(input logic [S:0] av_i, input logic [S-1:0] mv, input logic il,
                          output int lat_o);
        a = av_i; m = mv; if_last = il; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        lat_o = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (en_out) begin
                lat_o = n;
                break;
            end
        end
    endtask

    // After the en_out cycle: ready low now, strobe drops and ready rises next cycle.
    task automatic check_tail(input string tag);
        check({tag, "_rdy_during"}, {{S{1'b0}}, ready}, '0);
        @(posedge clk); #1;
        check({tag, "_en_out_drop"}, {{S{1'b0}}, en_out}, '0);
        check({tag, "_rdy_after"}, {{S{1'b0}}, ready}, {{S{1'b0}}, 1'b1});
    endtask

    initial begin
        m0   = {24{128'h7A3C_5E91_D2B4_0F68_C1E7_3A95_B806_4D2F}};
        ones = '0;
        ones[S-1:0] = '1;
        rst_n = 1'b1; en = 1'b0; if_last = 1'b0; a = '0; m = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_r", {1'b0, r}, '0);
        check("rst_en_out", {{S{1'b0}}, en_out}, '0);
        check("rst_ready", {{S{1'b0}}, ready}, {{S{1'b0}}, 1'b1});
        check("rst_sub_done", {{S{1'b0}}, sub_done}, '0);
        rst_n = 1'b0;
        @(posedge clk); #1;

        // a = m+5
        run_op({1'b0, m0} + (S+1)'(5), m0, 1'b1, lat);
        check("p5_lat", (S+1)'(lat), (S+1)'(25));
        check("p5_r", {1'b0, r}, (S+1)'(5));
        check("p5_sub", {{S{1'b0}}, sub_done}, {{S{1'b0}}, 1'b1});
        check_tail("p5");
        // r holds between results
        @(posedge clk); #1;
        check("p5_hold", {1'b0, r}, (S+1)'(5));

        // a = m-1
        av = {1'b0, m0} - (S+1)'(1);
        run_op(av, m0, 1'b1, lat);
        check("m1_lat", (S+1)'(lat), (S+1)'(25));
        check("m1_r", {1'b0, r}, av);
        check("m1_sub", {{S{1'b0}}, sub_done}, '0);
        check_tail("m1");

        // a = m
        run_op({1'b0, m0}, m0, 1'b1, lat);
        check("eq_r", {1'b0, r}, '0);
        check("eq_sub", {{S{1'b0}}, sub_done}, {{S{1'b0}}, 1'b1});
        check_tail("eq");

        // m=1, a=0: borrow ripples through every limb
        run_op('0, (S)'(1), 1'b1, lat);
        check("z_r", {1'b0, r}, '0);
        check("z_sub", {{S{1'b0}}, sub_done}, '0);
        check_tail("z");

        // m=1, a=2^S: top bit forces the take
        av = '0; av[S] = 1'b1;
        run_op(av, (S)'(1), 1'b1, lat);
        check("top_r", {1'b0, r}, ones);
        check("top_sub", {{S{1'b0}}, sub_done}, {{S{1'b0}}, 1'b1});
        check_tail("top");

        // pass-through, with the top bit set to show it is dropped
        av = {1'b1, {24{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}}};
        run_op(av, m0, 1'b0, lat);
        check("pass_lat", (S+1)'(lat), (S+1)'(PassLat));
        check("pass_r", {1'b0, r}, {1'b0, av[S-1:0]});
        check("pass_sub", {{S{1'b0}}, sub_done}, '0);
        check_tail("pass");

        // second en at edge k+10 mid-SUB is ignored
        a = {1'b0, m0} + (S+1)'(7); m = m0; if_last = 1'b1; en = 1'b1;
        @(posedge clk); #1;          // edge k
        en = 1'b0;
        repeat (9) @(posedge clk);   // edges k+1..k+9
        #1;
        a = '0; m = (S)'(1); if_last = 1'b0; en = 1'b1;
        @(posedge clk); #1;          // edge k+10
        en = 1'b0;
        cnt = 0; lat = 0;
        for (int n = 11; n <= 70; n++) begin
            @(posedge clk); #1;
            if (en_out) begin
                cnt++;
                if (lat == 0) lat = n;
            end
        end
        check("mid_lat", (S+1)'(lat), (S+1)'(25));
        check("mid_count", (S+1)'(cnt), (S+1)'(1));
        check("mid_r", {1'b0, r}, (S+1)'(7));

        // reset at edge k+12 of a fresh op abandons it
        a = {1'b0, m0} + (S+1)'(3); m = m0; if_last = 1'b1; en = 1'b1;
        @(posedge clk); #1;          // edge k
        en = 1'b0;
        repeat (11) @(posedge clk);  // edges k+1..k+11
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;          // edge k+12
        rst_n = 1'b0;
        check("ar_en_out", {{S{1'b0}}, en_out}, '0);
        check("ar_ready", {{S{1'b0}}, ready}, {{S{1'b0}}, 1'b1});
        check("ar_r", {1'b0, r}, '0);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (en_out) cnt++;
        end
        check("ar_no_out", (S+1)'(cnt), '0);

        // reset together with en: reset wins
        a = {1'b0, m0}; m = m0; if_last = 1'b1; en = 1'b1; rst_n = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; rst_n = 1'b0;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (en_out) cnt++;
        end
        check("rw_no_out", (S+1)'(cnt), '0);
        check("rw_ready", {{S{1'b0}}, ready}, {{S{1'b0}}, 1'b1});

        // a fresh op completes normally afterwards
        run_op({1'b0, m0} + (S+1)'(9), m0, 1'b1, lat);
        check("post_lat", (S+1)'(lat), (S+1)'(25));
        check("post_r", {1'b0, r}, (S+1)'(9));
        check("post_sub", {{S{1'b0}}, sub_done}, {{S{1'b0}}, 1'b1});
        check_tail("post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
